// File: rtl/one_to_two_st_demux.sv
// AXI4-Stream 1-to-2 packet demultiplexer. The route is locked for a whole packet and
// each output is registered through a 2-entry (main + skid) buffer.
module one_to_two_st_demux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_A,
    output logic                  m_axis_tvalid_A,
    input  logic                  m_axis_tready_A,
    output logic                  m_axis_tlast_A,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_B,
    output logic                  m_axis_tvalid_B,
    input  logic                  m_axis_tready_B,
    output logic                  m_axis_tlast_B
);

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t                state_q, state_d;
    logic                  rdy_en_q;
    logic                  dest;
    logic                  accept;
    logic [1:0]            m_ready;
    logic [1:0]            push;
    logic [1:0]            skid_full;
    logic [1:0]            out_valid;
    logic [1:0]            out_last;
    logic [DATA_WIDTH-1:0] out_data [2];

    assign m_ready = {m_axis_tready_B, m_axis_tready_A};

    always_comb begin
        dest = sel;
        case (state_q)
            LOCK_A:  dest = 1'b0;
            LOCK_B:  dest = 1'b1;
            default: dest = sel;
        endcase
    end

    // Ready depends only on registered state plus sel, never on downstream tready.
    assign s_axis_tready = rdy_en_q & ~skid_full[dest];
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !s_axis_tlast)
                    state_d = sel ? LOCK_B : LOCK_A;
            end
            LOCK_A, LOCK_B: begin
                if (accept && s_axis_tlast)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_out
            logic                  main_valid_q, main_valid_d;
            logic                  main_last_q, main_last_d;
            logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
            logic                  skid_valid_q, skid_valid_d;
            logic                  skid_last_q, skid_last_d;
            logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

            assign push[gi] = accept & (dest == 1'(gi));

            // A push never arrives while the skid is full, so the skid only fills on a stall.
            always_comb begin
                main_valid_d = main_valid_q;
                main_last_d  = main_last_q;
                main_data_d  = main_data_q;
                skid_valid_d = skid_valid_q;
                skid_last_d  = skid_last_q;
                skid_data_d  = skid_data_q;
                if (!main_valid_q || m_ready[gi]) begin
                    if (skid_valid_q) begin
                        main_valid_d = 1'b1;
                        main_last_d  = skid_last_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        main_valid_d = push[gi];
                        if (push[gi]) begin
                            main_last_d = s_axis_tlast;
                            main_data_d = s_axis_tdata;
                        end
                    end
                end else if (push[gi]) begin
                    skid_valid_d = 1'b1;
                    skid_last_d  = s_axis_tlast;
                    skid_data_d  = s_axis_tdata;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    main_valid_q <= 1'b0;
                    main_last_q  <= 1'b0;
                    main_data_q  <= '0;
                    skid_valid_q <= 1'b0;
                    skid_last_q  <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    main_valid_q <= main_valid_d;
                    main_last_q  <= main_last_d;
                    main_data_q  <= main_data_d;
                    skid_valid_q <= skid_valid_d;
                    skid_last_q  <= skid_last_d;
                    skid_data_q  <= skid_data_d;
                end
            end

            assign skid_full[gi] = skid_valid_q;
            assign out_valid[gi] = main_valid_q;
            assign out_last[gi]  = main_last_q;
            assign out_data[gi]  = main_data_q;
        end
    endgenerate

    assign m_axis_tvalid_A = out_valid[0];
    assign m_axis_tlast_A  = out_last[0];
    assign m_axis_tdata_A  = out_data[0];
    assign m_axis_tvalid_B = out_valid[1];
    assign m_axis_tlast_B  = out_last[1];
    assign m_axis_tdata_B  = out_data[1];

endmodule

// File: tb/tb_one_to_two_st_demux.sv
// Bench for one_to_two_st_demux: a queue-based reference model runs every cycle, alongside
// a vector table, hand-written corner-case sequences and a random phase.
module tb_one_to_two_st_demux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [31:0] da, db;
    logic        va, vb, la, lb;
    logic        ra = 1'b1, rb = 1'b1;

    int errors = 0;
    int checks = 0;
    int pops_a = 0;

    always #5 clk = ~clk;

    one_to_two_st_demux #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .m_axis_tdata_A(da), .m_axis_tvalid_A(va), .m_axis_tready_A(ra), .m_axis_tlast_A(la),
        .m_axis_tdata_B(db), .m_axis_tvalid_B(vb), .m_axis_tready_B(rb), .m_axis_tlast_B(lb)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-output FIFOs of {last,data}, holding at most two beats each,
    // plus the destination a packet is locked to (-1 = none).
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int          lock_dest = -1;
    bit          rdy_ok = 0;

    always @(negedge clk) begin
        int  d;
        bit  exp_rdy;
        bit  pa, pb;
        if (!reset) begin
            qa.delete();
            qb.delete();
            lock_dest = -1;
            rdy_ok = 0;
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_valid", {62'd0, va, vb}, 64'd0);
            chk("rst_data", {da, db}, 64'd0);
            chk("rst_last", {62'd0, la, lb}, 64'd0);
        end else begin
            d = (lock_dest >= 0) ? lock_dest : int'(sel);
            exp_rdy = rdy_ok && (((d == 0) ? qa.size() : qb.size()) < 2);
            chk("m_s_ready", 64'(s_ready), 64'(exp_rdy));
            chk("m_valid_a", 64'(va), 64'(qa.size() > 0));
            chk("m_valid_b", 64'(vb), 64'(qb.size() > 0));
            if (qa.size() > 0) chk("m_beat_a", 64'({la, da}), 64'(qa[0]));
            if (qb.size() > 0) chk("m_beat_b", 64'({lb, db}), 64'(qb[0]));
            if (va && ra) pops_a++;
            pa = (qa.size() > 0) && ra;
            pb = (qb.size() > 0) && rb;
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (s_valid && exp_rdy) begin
                if (d == 0) qa.push_back({s_last, s_data});
                else        qb.push_back({s_last, s_data});
                if (lock_dest < 0 && !s_last) lock_dest = d;
                else if (lock_dest >= 0 && s_last) lock_dest = -1;
            end
            rdy_ok = 1;
        end
    end

    typedef struct {
        logic        s, v;
        logic [31:0] d;
        logic        l;
        logic        eva;
        logic [31:0] eda;
        logic        ela;
        logic        evb;
        logic [31:0] edb;
        logic        elb;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [31:0] d, logic l,
                                logic eva, logic [31:0] eda, logic ela,
                                logic evb, logic [31:0] edb, logic elb);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.l = l;
        r.eva = eva; r.eda = eda; r.ela = ela;
        r.evb = evb; r.edb = edb; r.elb = elb;
        return r;
    endfunction

    task automatic send(input logic s, input logic [31:0] d, input logic l, output int waited);
        waited = 0;
        @(posedge clk); #1;
        sel = s; s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        int w;
        int idx;
        int stall_left;
        bit stall_started;
        int pops_start;

        tbl[0]  = mk(0, 1, 32'h1,  0, 0, 0, 0,        0, 0, 0);
        tbl[1]  = mk(0, 1, 32'h2,  0, 1, 32'h1, 0,    0, 0, 0);
        tbl[2]  = mk(0, 1, 32'h3,  0, 1, 32'h2, 0,    0, 0, 0);
        tbl[3]  = mk(0, 1, 32'h4,  1, 1, 32'h3, 0,    0, 0, 0);
        tbl[4]  = mk(1, 1, 32'h1,  0, 1, 32'h4, 1,    0, 0, 0);
        tbl[5]  = mk(1, 1, 32'h2,  0, 0, 0, 0,        1, 32'h1, 0);
        tbl[6]  = mk(1, 1, 32'h3,  0, 0, 0, 0,        1, 32'h2, 0);
        tbl[7]  = mk(1, 1, 32'h4,  1, 0, 0, 0,        1, 32'h3, 0);
        tbl[8]  = mk(0, 1, 32'h21, 0, 0, 0, 0,        1, 32'h4, 1);
        tbl[9]  = mk(1, 1, 32'h22, 0, 1, 32'h21, 0,   0, 0, 0);
        tbl[10] = mk(1, 1, 32'h23, 0, 1, 32'h22, 0,   0, 0, 0);
        tbl[11] = mk(1, 1, 32'h24, 1, 1, 32'h23, 0,   0, 0, 0);
        tbl[12] = mk(1, 1, 32'h31, 1, 1, 32'h24, 1,   0, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,  0, 0, 0, 0,        1, 32'h31, 1);
        tbl[14] = mk(0, 0, 32'h0,  0, 0, 0, 0,        0, 0, 0);

        // Reset held with a valid beat pending; ready must stay low until the first edge after release.
        s_valid = 1'b1; s_data = 32'h11;
        repeat (3) @(posedge clk);
        #1; reset = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready_low", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("rel_ready_high", 64'(s_ready), 64'd1);

        // Basic routing to A then B, then the locked-route packet.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            sel = tbl[i].s; s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l;
            @(negedge clk);
            chk($sformatf("tbl%0d_s_ready", i), 64'(s_ready), 64'd1);
            chk($sformatf("tbl%0d_va", i), 64'(va), 64'(tbl[i].eva));
            chk($sformatf("tbl%0d_vb", i), 64'(vb), 64'(tbl[i].evb));
            if (tbl[i].eva) chk($sformatf("tbl%0d_a", i), 64'({la, da}), 64'({tbl[i].ela, tbl[i].eda}));
            if (tbl[i].evb) chk($sformatf("tbl%0d_b", i), 64'({lb, db}), 64'({tbl[i].elb, tbl[i].edb}));
        end

        // Backpressure: A stalls for 7 cycles once two beats are in.
        idx = 0; stall_left = 0; stall_started = 0; pops_start = pops_a;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (!stall_started && idx == 2) begin
                stall_started = 1;
                stall_left = 7;
            end
            ra = (stall_left == 0);
            sel = 1'b0;
            s_valid = (idx < 11);
            s_data = 32'h10 + 32'(idx);
            s_last = (idx == 10);
            @(negedge clk);
            if (stall_left > 0) begin
                if (stall_left <= 6) begin
                    chk("bp_s_ready", 64'(s_ready), 64'd0);
                    chk("bp_hold_a", 64'({va, la, da}), 64'({1'b1, 1'b0, 32'h11}));
                end
                stall_left--;
            end
            if (s_valid && s_ready) idx++;
        end
        ra = 1'b1;
        chk("bp_all_sent", 64'(idx), 64'd11);
        chk("bp_a_beats", 64'(pops_a - pops_start), 64'd11);
        idle_cycle();

        // Independence: A holds two beats, a single-beat packet to B still passes.
        ra = 1'b0;
        send(0, 32'h40, 0, w);
        send(0, 32'h41, 1, w);
        send(1, 32'hBB, 1, w);
        chk("ind_no_wait", 64'(w), 64'd0);
        idle_cycle();
        @(negedge clk);
        chk("ind_b", 64'({vb, lb, db}), 64'({1'b1, 1'b1, 32'hBB}));
        chk("ind_a_held", 64'({va, la, da}), 64'({1'b1, 1'b0, 32'h40}));
        @(posedge clk); #1; ra = 1'b1;
        repeat (3) idle_cycle();

        // Reset in the middle of a packet to A.
        ra = 1'b0;
        send(0, 32'h50, 0, w);
        send(0, 32'h51, 0, w);
        @(posedge clk); #1;
        s_valid = 1'b0; reset = 1'b0;
        #1;
        chk("mid_rst_va", 64'(va), 64'd0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1; ra = 1'b1;
        send(1, 32'h60, 0, w);
        send(1, 32'h61, 1, w);
        idle_cycle();
        @(negedge clk);
        chk("mid_rst_b", 64'({vb, lb, db}), 64'({1'b1, 1'b1, 32'h61}));
        chk("mid_rst_a_idle", 64'(va), 64'd0);

        // Random traffic with random backpressure, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            sel = 1'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = $urandom;
            s_last = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 9) < 7);
            rb = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; ra = 1'b1; rb = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'({va, vb}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/one_to_two_st_demux.md
# one_to_two_st_demux

AXI4-Stream 1-to-2 packet demultiplexer: routes one slave stream to one of two master streams, A or B, chosen by `sel`. It is the splitting counterpart of the 2-to-1 stream mux in the Axis_Mux design. The route is locked per packet, so a packet is never split across outputs. Each output has a 2-entry skid buffer, which gives full throughput with registered outputs.

## Interface
- `DATA_WIDTH`, 32, width of all tdata buses.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sel`  in  1  destination select: 0 = A, 1 = B. Sampled only at packet start.
- `s_axis_tdata`  in  DATA_WIDTH  input data.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input beat accepted when high with tvalid.
- `s_axis_tlast`  in  1  last beat of packet.
- `m_axis_tdata_A` / `m_axis_tvalid_A` / `m_axis_tready_A` (in) / `m_axis_tlast_A`  DATA_WIDTH/1/1/1  output stream A.
- `m_axis_tdata_B` / `m_axis_tvalid_B` / `m_axis_tready_B` (in) / `m_axis_tlast_B`  DATA_WIDTH/1/1/1  output stream B.

## Operation
- **Route FSM states:** IDLE, LOCK_A, LOCK_B.
- **Effective destination:**
  - `sel` while in IDLE.
  - A while in LOCK_A.
  - B while in LOCK_B.
- **IDLE:** the first accepted beat with tlast=0 moves the FSM to LOCK_A (sel=0) or LOCK_B (sel=1). A beat with tlast=1 (single-beat packet) is routed and the FSM stays in IDLE.
- **LOCK_x:** all accepted beats go to x. Changes on `sel` are ignored. Acceptance of a beat with tlast=1 returns the FSM to IDLE.
- **Per-output skid buffer:**
  - Main register drives the `m_axis_*` outputs.
  - Skid register catches one beat when the output stalls.
  - Beat order is preserved within each output.
- **Input ready:** `s_axis_tready` = NOT(skid register of the effective destination is full). It comes from registered state only, with no combinational path from `m_axis_tready_*`. It depends on the other output only through `sel`.
- **Output independence:** A and B drain independently. A stalled output never blocks a beat destined for the other output once the lock is released.
- **Data path:** tdata and tlast pass unmodified. There is no arithmetic and no width change.

## Timing
- **Reset values (asynchronous, active-low):**
  - All `m_axis_tvalid_*` = 0, `m_axis_tdata_*` = 0, `m_axis_tlast_*` = 0.
  - `s_axis_tready` = 0 while `reset` is low. It rises on the first `clk` edge after release.
  - FSM in IDLE, both skid registers empty.
- **Latency:** a beat accepted at edge N appears on `m_axis_tvalid_x` after edge N, i.e. 1 cycle.
- **Throughput:** one beat per cycle per packet stream when the destination tready is held high.
- **Backpressure:**
  - With destination tready low, the main register holds, and the skid register takes one more beat.
  - `s_axis_tready` then drops in the next cycle. At most 2 beats are buffered per output.
- **Release:**
  - When tready returns high, the main register is emitted first, then the skid register.
  - `s_axis_tready` re-asserts in the cycle after the skid register empties.
- **Stability:** `m_axis_tvalid_x`, `m_axis_tdata_x` and `m_axis_tlast_x` hold stable while tvalid=1 and tready=0 (AXI-S rule). tvalid never drops without a handshake.
- **sel toggle on the first beat's edge:** the value of `sel` at the accepting edge decides the route.
- **Reset mid-packet:** buffered beats are discarded, the FSM returns to IDLE, and the next accepted beat starts a new packet.
- **tvalid without tready:** no state change and no FSM transition.

## Test plan
1. **Reset:** hold `reset`=0 for 3 cycles with s_tvalid=1, data=0x11 -> tready_s=0, both m_tvalid=0. After release, tready_s=1 at the next edge.
2. **Basic routing:**
   - sel=0, packet 4 beats 0x1..0x4 (tlast on 0x4), m_tready_A=1 -> A outputs 0x1..0x4 in consecutive cycles with 1-cycle latency and tlast on 0x4; m_tvalid_B stays 0.
   - Repeat with sel=1 -> same beats on B.
3. **Lock:** sel=0 at the first beat of a 4-beat packet, then sel=1 on beat 2 -> all 4 beats on A. The next packet (sel=1) goes to B.
4. **Backpressure:**
   - sel=0, stream 0x10..0x1A continuously, m_tready_A=0 for 7 cycles after beat 2 -> s_tready drops after 2 beats are buffered.
   - On release, data exits in order 0x10..0x1A with no loss or duplication.
   - Outputs stay stable during the stall.
5. **Independence:** A stalled holding 2 beats, then a single-beat packet with sel=1 (data 0xBB, tlast=1) -> accepted immediately, m_tvalid_B=1 with 0xBB next cycle while A remains held.
6. **Mid-packet reset:** assert reset after beat 2 of a 4-beat packet to A -> A outputs clear immediately. After release, a new packet with sel=1 routes to B.
